// File: rtl/seq_counter_ctrl.sv
// Command-driven sequencer for the 6-bit prime/Fibonacci counter: accepts a run
// command, issues one counter step every two cycles, stops or bounces at endpoints.
module seq_counter_ctrl #(
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned PRIME_MIN = 2,
    parameter int unsigned PRIME_MAX = 31,
    parameter int unsigned FIB_MIN   = 0,
    parameter int unsigned FIB_MAX   = 55
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_seq,
    input  logic              cmd_ud,
    input  logic              cmd_bounce,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    input  logic [5:0]        cnt_q,
    output logic              cnt_en,
    output logic              cnt_seq,
    output logic              cnt_ud,
    output logic              busy,
    output logic              done,
    output logic              end_hit,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_seq;
    logic              r_ud;
    logic              r_bounce;
    logic              r_end_hit;
    logic              r_aborted;
    logic [STEP_W-1:0] r_remaining;
    logic [STEP_W-1:0] r_steps_done;
    logic [5:0]        w_endpoint;
    logic              w_at_end;

    // Endpoint depends on the direction currently driven to the counter.
    always_comb begin
        w_endpoint = '0;
        if (r_ud) w_endpoint = r_seq ? 6'(FIB_MIN) : 6'(PRIME_MIN);
        else      w_endpoint = r_seq ? 6'(FIB_MAX) : 6'(PRIME_MAX);
    end

    assign w_at_end = (cnt_q == w_endpoint);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (cmd_valid) w_next = S_EVAL;
            S_EVAL: begin
                if (abort)                    w_next = S_DONE;
                else if (r_remaining == '0)   w_next = S_DONE;
                else if (w_at_end && !r_bounce) w_next = S_DONE;
                else                          w_next = S_ISSUE;
            end
            S_ISSUE: w_next = abort ? S_DONE : S_EVAL;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seq        <= 1'b0;
            r_ud         <= 1'b0;
            r_bounce     <= 1'b0;
            r_end_hit    <= 1'b0;
            r_aborted    <= 1'b0;
            r_remaining  <= '0;
            r_steps_done <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_seq        <= cmd_seq;
                        r_ud         <= cmd_ud;
                        r_bounce     <= cmd_bounce;
                        r_remaining  <= cmd_steps;
                        r_steps_done <= '0;
                        r_end_hit    <= 1'b0;
                        r_aborted    <= 1'b0;
                    end
                end
                S_EVAL: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                    end else if (r_remaining != '0 && w_at_end) begin
                        if (r_bounce) r_ud <= ~r_ud;
                        else          r_end_hit <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_remaining <= r_remaining - 1'b1;
                    if (r_steps_done != '1) r_steps_done <= r_steps_done + 1'b1;
                    if (abort) r_aborted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign cnt_en     = (r_state == S_ISSUE);
    assign done       = (r_state == S_DONE);
    assign cnt_seq    = r_seq;
    assign cnt_ud     = r_ud;
    assign end_hit    = r_end_hit;
    assign aborted    = r_aborted;
    assign steps_done = r_steps_done;

endmodule
